fb_swap_ctrl: RTL and testbench

FB_SWAP_CTRL -- requirements
Module: fb_swap_ctrl

---
 rtl/fb_pkg.sv | 40 ++++
 rtl/fb_swap_ctrl_if.sv | 26 ++
 rtl/fb_clear_walker.sv | 43 ++++
 rtl/fb_swap_ctrl.sv | 129 ++++++++++++
 tb/tb_fb_swap_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared constants and types for the LED panel double-buffered frame store.
package fb_pkg;

  // Pixel words per panel half per bank.
  localparam int FB_WORDS     = 2048;
  // Pixel width in bits, laid out as {X,X,R,R,G,G,B,B}.
  localparam int PIX_W        = 8;
  // Word address width inside one panel half.
  localparam int FB_ADDR_W    = 11;
  // CPU address carries one extra bit above the word address to pick the half.
  localparam int CPU_ADDR_W   = FB_ADDR_W + 1;
  // Bit of the CPU address that selects the half: 0 = top, 1 = bottom.
  localparam int HALF_SEL_BIT = FB_ADDR_W;

  // Controller state encoding; kept as plain constants so the encoding is fixed.
  typedef logic [1:0] fb_state_t;
  localparam fb_state_t ST_IDLE         = 2'd0;
  localparam fb_state_t ST_CLEARING     = 2'd1;
  localparam fb_state_t ST_SWAP_PENDING = 2'd2;

  // One back-bank write as it leaves the controller.
  typedef struct packed {
    logic                 we_top;
    logic                 we_bot;
    logic [FB_ADDR_W-1:0] addr;
    logic [PIX_W-1:0]     data;
  } fb_wr_t;

  // Split a CPU pixel write into the per-half enables and the word address.
  function automatic fb_wr_t cpu_write(input logic [CPU_ADDR_W-1:0] cpu_addr,
                                       input logic [PIX_W-1:0]      cpu_data);
    fb_wr_t wr;
    wr.we_top = ~cpu_addr[HALF_SEL_BIT];
    wr.we_bot =  cpu_addr[HALF_SEL_BIT];
    wr.addr   =  cpu_addr[FB_ADDR_W-1:0];
    wr.data   =  cpu_data;
    return wr;
  endfunction

endpackage

// File: rtl/fb_swap_ctrl_if.sv
// CPU-side request/handshake bundle of the frame-buffer swap controller.
interface fb_swap_ctrl_if;
  import fb_pkg::*;

  logic                  cpu_we;
  logic [CPU_ADDR_W-1:0] cpu_addr;
  logic [PIX_W-1:0]      cpu_data;
  logic                  cpu_clear;
  logic [PIX_W-1:0]      cpu_fill;
  logic                  cpu_swap;
  logic                  cpu_ready;
  logic                  swap_ack;

  // The CPU issues requests and watches ready/ack.
  modport master (
    output cpu_we, cpu_addr, cpu_data, cpu_clear, cpu_fill, cpu_swap,
    input  cpu_ready, swap_ack
  );

  // The controller accepts requests and reports ready/ack.
  modport slave (
    input  cpu_we, cpu_addr, cpu_data, cpu_clear, cpu_fill, cpu_swap,
    output cpu_ready, swap_ack
  );

endinterface

// File: rtl/fb_clear_walker.sv
// Address walker for a back-bank clear: steps 0..FB_WORDS-1 once per cycle
// and holds the fill value latched at start.
module fb_clear_walker
  import fb_pkg::*;
#(
  parameter int WORDS = FB_WORDS,
  parameter int PW    = PIX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PW-1:0]        fill_in,
  output logic [FB_ADDR_W-1:0] addr,
  output logic [PW-1:0]        fill,
  output logic                 active,
  output logic                 last
);

  // The word currently presented is the final one of the bank.
  assign last = active && (addr == FB_ADDR_W'(WORDS - 1));

  // Walk the address while active; stop after presenting the final word.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr   <= '0;
      fill   <= '0;
      active <= 1'b0;
    end else if (start) begin
      // NOTE: state registers use non-blocking assignments so every flop in
      // the design samples the pre-edge values, independent of block order.
      addr   <= '0;
      fill   <= fill_in;
      active <= 1'b1;
    end else if (active) begin
      if (last) begin
        active <= 1'b0;
      end else begin
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_swap_ctrl.sv
// Double-buffered LED frame store controller: routes CPU pixel writes and
// bank clears to the back bank, and swaps banks only at a frame boundary.
module fb_swap_ctrl
  import fb_pkg::*;
#(
  parameter int FB_WORDS = fb_pkg::FB_WORDS,
  parameter int PIX_W    = fb_pkg::PIX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 disp_done,
  fb_swap_ctrl_if.slave        cpu,
  output logic                 front_bank,
  output logic                 ram_we_top,
  output logic                 ram_we_bot,
  output logic [FB_ADDR_W-1:0] ram_wr_addr,
  output logic [PIX_W-1:0]     ram_wr_data,
  output logic [15:0]          frame_count
);

  fb_state_t            state;
  logic                 swap_ack_q;
  logic                 acc_clear;
  logic                 acc_swap;
  logic                 acc_we;
  logic [FB_ADDR_W-1:0] clr_addr;
  logic [PIX_W-1:0]     clr_fill;
  logic                 clr_active;
  logic                 clr_last;
  fb_wr_t               cpu_wr;

  // Requests are only taken in IDLE, and never while reset is asserted.
  assign cpu.cpu_ready = (state == ST_IDLE) && !rst;
  assign cpu.swap_ack  = swap_ack_q;

  // Clear beats swap beats write; losers in the same cycle are simply dropped.
  assign acc_clear = cpu.cpu_ready && cpu.cpu_clear;
  assign acc_swap  = cpu.cpu_ready && cpu.cpu_swap && !cpu.cpu_clear;
  assign acc_we    = cpu.cpu_ready && cpu.cpu_we && !cpu.cpu_clear && !cpu.cpu_swap;

  assign cpu_wr = cpu_write(cpu.cpu_addr, cpu.cpu_data);

  fb_clear_walker #(
    .WORDS (FB_WORDS),
    .PW    (PIX_W)
  ) u_walker (
    .clk     (clk),
    .rst     (rst),
    .start   (acc_clear),
    .fill_in (cpu.cpu_fill),
    .addr    (clr_addr),
    .fill    (clr_fill),
    .active  (clr_active),
    .last    (clr_last)
  );

  // Control FSM: bank-clear sequencing and frame-synchronous bank swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      front_bank <= 1'b0;
      swap_ack_q <= 1'b0;
    end else begin
      swap_ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A disp_done in this same cycle belongs to the frame already
          // showing, so it cannot complete the swap being requested now.
          if (acc_clear) begin
            state <= ST_CLEARING;
          end else if (acc_swap) begin
            state <= ST_SWAP_PENDING;
          end
        end
        ST_CLEARING: begin
          // The walker drops active after its final word; leaving one cycle
          // later keeps cpu_ready low while that last write is on the bus.
          if (!clr_active) begin
            state <= ST_IDLE;
          end
        end
        ST_SWAP_PENDING: begin
          if (disp_done) begin
            front_bank <= ~front_bank;
            swap_ack_q <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered back-bank write port: clear words take precedence over CPU writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we_top  <= 1'b0;
      ram_we_bot  <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
    end else begin
      // NOTE: enables default low every cycle; address and data are left
      // unassigned on idle cycles so those flops hold their last value.
      ram_we_top <= 1'b0;
      ram_we_bot <= 1'b0;
      if (state == ST_CLEARING && clr_active) begin
        ram_we_top  <= 1'b1;
        ram_we_bot  <= 1'b1;
        ram_wr_addr <= clr_addr;
        ram_wr_data <= clr_fill;
      end else if (acc_we) begin
        ram_we_top  <= cpu_wr.we_top;
        ram_we_bot  <= cpu_wr.we_bot;
        ram_wr_addr <= cpu_wr.addr;
        ram_wr_data <= cpu_wr.data;
      end
    end
  end

  // Frame counter: counts every display end-of-frame pulse, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
    end else if (disp_done) begin
      frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed self-checking bench for fb_swap_ctrl.
module tb_fb_swap_ctrl;
  import fb_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 disp_done = 1'b0;
  logic                 front_bank;
  logic                 ram_we_top;
  logic                 ram_we_bot;
  logic [FB_ADDR_W-1:0] ram_wr_addr;
  logic [PIX_W-1:0]     ram_wr_data;
  logic [15:0]          frame_count;

  fb_swap_ctrl_if bus ();

  fb_swap_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .disp_done   (disp_done),
    .cpu         (bus),
    .front_bank  (front_bank),
    .ram_we_top  (ram_we_top),
    .ram_we_bot  (ram_we_bot),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_fc   = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 ns so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    if (disp_done && !rst) exp_fc = exp_fc + 16'd1;
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_data  = '0;
    bus.cpu_clear = 1'b0;
    bus.cpu_fill  = '0;
    bus.cpu_swap  = 1'b0;
  endtask

  initial begin
    int good;
    int nwr;
    logic fb_before;

    idle_inputs();

    // ---- reset state
    rst = 1'b1;
    step();
    step();
    check("rst_ready",   bus.cpu_ready, 0);
    check("rst_front",   front_bank,    0);
    check("rst_ack",     bus.swap_ack,  0);
    check("rst_we",      {ram_we_top, ram_we_bot}, 0);
    check("rst_addr",    ram_wr_addr,   0);
    check("rst_data",    ram_wr_data,   0);
    check("rst_fc",      frame_count,   0);
    rst = 1'b0;
    exp_fc = '0;
    step();
    check("post_rst_ready", bus.cpu_ready, 1);

    // ---- pixel write to bottom half
    bus.cpu_we = 1'b1; bus.cpu_addr = 12'h805; bus.cpu_data = 8'h2A;
    step();
    idle_inputs();
    check("wr_bot_we_bot", ram_we_bot,  1);
    check("wr_bot_we_top", ram_we_top,  0);
    check("wr_bot_addr",   ram_wr_addr, 11'h005);
    check("wr_bot_data",   ram_wr_data, 8'h2A);
    step();
    check("wr_idle_we",    {ram_we_top, ram_we_bot}, 0);
    check("wr_hold_addr",  ram_wr_addr, 11'h005);
    check("wr_hold_data",  ram_wr_data, 8'h2A);

    // ---- pixel write to top half, highest word
    bus.cpu_we = 1'b1; bus.cpu_addr = 12'h7FF; bus.cpu_data = 8'hC3;
    step();
    idle_inputs();
    check("wr_top_we", {ram_we_top, ram_we_bot}, 2'b10);
    check("wr_top_addr", ram_wr_addr, 11'h7FF);
    check("wr_top_data", ram_wr_data, 8'hC3);

    // ---- full clear, with stray requests injected mid-clear
    bus.cpu_clear = 1'b1; bus.cpu_fill = 8'h15;
    step();
    idle_inputs();
    check("clr_ready_lo", bus.cpu_ready, 0);
    check("clr_first_we", {ram_we_top, ram_we_bot}, 0);
    good = 0;
    for (int i = 0; i < FB_WORDS; i++) begin
      if (i >= 500 && i < 504) begin
        bus.cpu_we = 1'b1; bus.cpu_addr = 12'h900; bus.cpu_data = 8'hEE;
        bus.cpu_swap = 1'b1; bus.cpu_clear = 1'b1; bus.cpu_fill = 8'h77;
      end else begin
        idle_inputs();
      end
      step();
      if (ram_we_top === 1'b1 && ram_we_bot === 1'b1 && ram_wr_addr === 11'(i) &&
          ram_wr_data === 8'h15 && bus.cpu_ready === 1'b0)
        good++;
    end
    idle_inputs();
    check("clr_words_ok", good, FB_WORDS);
    check("clr_last_addr", ram_wr_addr, 11'h7FF);
    step();
    check("clr_done_ready", bus.cpu_ready, 1);
    check("clr_done_we", {ram_we_top, ram_we_bot}, 0);
    check("clr_front_kept", front_bank, 0);

    // ---- swap with disp_done 40 cycles later
    bus.cpu_swap = 1'b1;
    step();
    idle_inputs();
    check("swap_pend_ready", bus.cpu_ready, 0);
    good = 0;
    for (int i = 0; i < 39; i++) begin
      step();
      if (bus.swap_ack === 1'b0 && front_bank === 1'b0) good++;
    end
    check("swap_wait_quiet", good, 39);
    disp_done = 1'b1;
    step();
    disp_done = 1'b0;
    check("swap1_front", front_bank, 1);
    check("swap1_ack", bus.swap_ack, 1);
    check("swap1_ready", bus.cpu_ready, 1);
    step();
    check("swap1_ack_once", bus.swap_ack, 0);
    check("swap1_fc", frame_count, exp_fc);

    // second swap returns to bank 0
    bus.cpu_swap = 1'b1;
    step();
    idle_inputs();
    step();
    step();
    disp_done = 1'b1;
    step();
    disp_done = 1'b0;
    check("swap2_front", front_bank, 0);
    check("swap2_ack", bus.swap_ack, 1);

    // ---- clear + swap + write together: clear only
    step();
    bus.cpu_clear = 1'b1; bus.cpu_fill = 8'h3C;
    bus.cpu_swap = 1'b1;
    bus.cpu_we = 1'b1; bus.cpu_addr = 12'h123; bus.cpu_data = 8'h99;
    step();
    idle_inputs();
    check("coll_no_write", {ram_we_top, ram_we_bot}, 0);
    check("coll_ready_lo", bus.cpu_ready, 0);
    nwr = 0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.cpu_ready === 1'b1) break;
      step();
      if (ram_we_top === 1'b1 && ram_we_bot === 1'b1 && ram_wr_data === 8'h3C) nwr++;
    end
    check("coll_ready_back", bus.cpu_ready, 1);
    check("coll_clear_words", nwr, FB_WORDS);
    check("coll_front_kept", front_bank, 0);
    step();
    check("coll_no_swap_ack", bus.swap_ack, 0);

    // ---- swap accepted together with disp_done: needs the next disp_done
    bus.cpu_swap = 1'b1; disp_done = 1'b1;
    step();
    idle_inputs(); disp_done = 1'b0;
    check("coinc_front", front_bank, 0);
    check("coinc_ack", bus.swap_ack, 0);
    check("coinc_pending", bus.cpu_ready, 0);
    step();
    step();
    disp_done = 1'b1;
    step();
    disp_done = 1'b0;
    check("coinc_done_front", front_bank, 1);
    check("coinc_done_ack", bus.swap_ack, 1);
    check("coinc_fc", frame_count, exp_fc);

    // ---- reset in the middle of a clear, at word 1000
    step();
    bus.cpu_clear = 1'b1; bus.cpu_fill = 8'h5A;
    step();
    idle_inputs();
    for (int i = 0; i <= 1000; i++) step();
    check("mid_clr_addr", ram_wr_addr, 11'd1000);
    rst = 1'b1;
    step();
    check("mid_rst_we", {ram_we_top, ram_we_bot}, 0);
    check("mid_rst_ready", bus.cpu_ready, 0);
    check("mid_rst_front", front_bank, 0);
    check("mid_rst_fc", frame_count, 0);
    rst = 1'b0;
    exp_fc = '0;
    good = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ram_we_top === 1'b0 && ram_we_bot === 1'b0 && bus.cpu_ready === 1'b1) good++;
    end
    check("mid_rst_no_writes", good, 20);

    // ---- reset while a swap is pending cancels it
    bus.cpu_swap = 1'b1;
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_fc = '0;
    disp_done = 1'b1;
    step();
    disp_done = 1'b0;
    check("swp_rst_ack", bus.swap_ack, 0);
    check("swp_rst_front", front_bank, 0);
    check("swp_rst_ready", bus.cpu_ready, 1);

    // ---- frame counter wrap
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_fc = '0;
    disp_done = 1'b1;
    for (int i = 0; i < 65535; i++) step();
    check("fc_max", frame_count, 16'hFFFF);
    step();
    disp_done = 1'b0;
    check("fc_wrap", frame_count, 16'h0000);
    check("fc_model", frame_count, exp_fc);
    check("fc_front_kept", front_bank, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
